// File: rtl/conv_tile_sequencer.sv
// Convolution tile sequencer: drives the line buffer, the window sequencer and
// the vector compute unit over a whole frame. K x K kernel, T input-channel
// tiles accumulated per output window, W strips per row, H rows.
//
// Handshake: a strip is transferred in every cycle where in_valid & in_ready
// are both high. in_valid may rise or fall at any time. in_ready is a function
// of registered state only, so it never depends on in_valid. lb_shift_en
// mirrors the transfer.
module conv_tile_sequencer #(
  parameter int MAX_K        = 5,
  parameter int MAX_IC_TILES = 16,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       cfg_kernel_size,
  input  logic [CNT_W-1:0] cfg_width_strips,
  input  logic [CNT_W-1:0] cfg_height,
  input  logic [4:0]       cfg_ic_tiles,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             lb_shift_en,
  output logic             seq_load,
  output logic [CNT_W-1:0] seq_row_idx,
  output logic [CNT_W-1:0] seq_col_idx,
  output logic [2:0]       kernel_y,
  output logic [2:0]       kernel_x,
  output logic [4:0]       ic_tile_idx,
  output logic             cu_clear,
  output logic             cu_en,
  output logic             acc_last,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL    = 3'd1,
    S_LOAD    = 3'd2,
    S_MAC     = 3'd3,
    S_ADVANCE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t state, state_nx;

  // Frame configuration captured at start
  logic [2:0]       k_q;
  logic [CNT_W-1:0] w_q, h_q;
  logic [4:0]       t_q;
  logic             err_q;

  // Output-window position, input-strip position, MAC tap position
  logic [CNT_W-1:0] row_q, col_q, in_row_q, in_col_q;
  logic [2:0]       kx_q, ky_q;
  logic [4:0]       tile_q;

  logic             cfg_ok, accept, in_col_last, fill_done;
  logic             mac_last, col_last, row_last;
  logic [2:0]       half_k;
  logic [CNT_W:0]   row_plus, need_rows, rows_after;

  assign cfg_ok = cfg_kernel_size[0]
               && (32'(cfg_kernel_size) <= 32'(MAX_K))
               && (cfg_width_strips != '0)
               && (cfg_height != '0)
               && (cfg_ic_tiles != '0)
               && (32'(cfg_ic_tiles) <= 32'(MAX_IC_TILES));

  // Rows that must be in the line buffer before output row row_q can start:
  // the row itself plus the P rows below it, clipped at the frame bottom.
  assign half_k     = (k_q - 3'd1) >> 1;
  assign row_plus   = {1'b0, row_q} + (CNT_W+1)'(half_k) + (CNT_W+1)'(1);
  assign need_rows  = (row_plus > {1'b0, h_q}) ? {1'b0, h_q} : row_plus;

  assign in_ready    = (state == S_FILL) && ({1'b0, in_row_q} < need_rows);
  assign accept      = in_valid & in_ready;
  assign lb_shift_en = accept;

  // FILL may end in the same cycle as the strip that closes the deficit
  assign in_col_last = (in_col_q == w_q - CNT_W'(1));
  assign rows_after  = {1'b0, in_row_q} + (CNT_W+1)'(accept && in_col_last);
  assign fill_done   = (rows_after >= need_rows);

  assign mac_last = (kx_q == k_q - 3'd1) && (ky_q == k_q - 3'd1)
                 && (tile_q == t_q - 5'd1);
  assign col_last = (col_q == w_q - CNT_W'(1));
  assign row_last = (({1'b0, row_q} + (CNT_W+1)'(1)) >= {1'b0, h_q});

  // Outputs decode registered state and counters only
  assign seq_load    = (state == S_LOAD);
  assign cu_clear    = (state == S_LOAD);
  assign cu_en       = (state == S_MAC);
  assign acc_last    = (state == S_MAC) && mac_last;
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign cfg_err     = (state == S_DONE) && err_q;
  assign seq_row_idx = row_q;
  assign seq_col_idx = col_q;
  assign kernel_y    = ky_q;
  assign kernel_x    = kx_q;
  assign ic_tile_idx = tile_q;
  assign dbg_state   = state;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (start) state_nx = cfg_ok ? S_FILL : S_DONE;
      S_FILL:    if (fill_done) state_nx = S_LOAD;
      S_LOAD:    state_nx = S_MAC;
      S_MAC:     if (mac_last) state_nx = S_ADVANCE;
      S_ADVANCE: begin
        if (!col_last)     state_nx = S_LOAD;
        else if (row_last) state_nx = S_DONE;
        else               state_nx = S_FILL;
      end
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Config capture and position counters
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q      <= '0;
      w_q      <= '0;
      h_q      <= '0;
      t_q      <= '0;
      err_q    <= 1'b0;
      row_q    <= '0;
      col_q    <= '0;
      in_row_q <= '0;
      in_col_q <= '0;
      kx_q     <= '0;
      ky_q     <= '0;
      tile_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            k_q      <= cfg_kernel_size;
            w_q      <= cfg_width_strips;
            h_q      <= cfg_height;
            t_q      <= cfg_ic_tiles;
            err_q    <= !cfg_ok;
            row_q    <= '0;
            col_q    <= '0;
            in_row_q <= '0;
            in_col_q <= '0;
          end
        end
        S_FILL: begin
          if (accept) begin
            if (in_col_last) begin
              in_col_q <= '0;
              in_row_q <= in_row_q + CNT_W'(1);
            end else begin
              in_col_q <= in_col_q + CNT_W'(1);
            end
          end
        end
        S_MAC: begin
          // kernel_x innermost, then kernel_y, then IC tile; all wrap to 0
          if (kx_q == k_q - 3'd1) begin
            kx_q <= '0;
            if (ky_q == k_q - 3'd1) begin
              ky_q   <= '0;
              tile_q <= (tile_q == t_q - 5'd1) ? 5'd0 : tile_q + 5'd1;
            end else begin
              ky_q <= ky_q + 3'd1;
            end
          end else begin
            kx_q <= kx_q + 3'd1;
          end
        end
        S_ADVANCE: begin
          if (col_last) begin
            col_q <= '0;
            row_q <= row_q + CNT_W'(1);
          end else begin
            col_q <= col_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          // Leave indices at zero for IDLE
          err_q    <= 1'b0;
          row_q    <= '0;
          col_q    <= '0;
          in_row_q <= '0;
          in_col_q <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_tile_sequencer.sv
// Bench for conv_tile_sequencer: directed frames from the test plan plus
// randomized frames, checked against a loop-nest reference of the window/tap
// order and an arithmetic model of frame length.
module tb_conv_tile_sequencer;

  localparam int CNT_W = 16;
  localparam int TW    = 44;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [2:0]       cfg_kernel_size;
  logic [CNT_W-1:0] cfg_width_strips;
  logic [CNT_W-1:0] cfg_height;
  logic [4:0]       cfg_ic_tiles;
  logic             in_valid;
  logic             in_ready, lb_shift_en, seq_load;
  logic [CNT_W-1:0] seq_row_idx, seq_col_idx;
  logic [2:0]       kernel_y, kernel_x;
  logic [4:0]       ic_tile_idx;
  logic             cu_clear, cu_en, acc_last, busy, done, cfg_err;
  logic [2:0]       dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // Expected MAC taps: {row, col, tile, ky, kx, acc_last}
  logic [TW-1:0] exp_q[$];

  conv_tile_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_kernel_size(cfg_kernel_size), .cfg_width_strips(cfg_width_strips),
    .cfg_height(cfg_height), .cfg_ic_tiles(cfg_ic_tiles),
    .in_valid(in_valid), .in_ready(in_ready), .lb_shift_en(lb_shift_en),
    .seq_load(seq_load), .seq_row_idx(seq_row_idx), .seq_col_idx(seq_col_idx),
    .kernel_y(kernel_y), .kernel_x(kernel_x), .ic_tile_idx(ic_tile_idx),
    .cu_clear(cu_clear), .cu_en(cu_en), .acc_last(acc_last),
    .busy(busy), .done(done), .cfg_err(cfg_err), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] all_outputs();
    return {12'd0, in_ready, lb_shift_en, seq_load, seq_row_idx, seq_col_idx,
            kernel_y, kernel_x, ic_tile_idx, cu_clear, cu_en, acc_last,
            busy, done, cfg_err};
  endfunction

  // Rows that must be buffered before output row r starts
  function automatic int need_rows(input int r, input int k, input int h);
    int v;
    v = r + (k - 1) / 2 + 1;
    return (v < h) ? v : h;
  endfunction

  // Frame length from start to done with in_valid always high
  function automatic int model_latency(input int k, input int w, input int h, input int t);
    int lat, f;
    lat = 0;
    for (int r = 0; r < h; r++) begin
      f = (r == 0) ? need_rows(0, k, h) * w
                   : (need_rows(r, k, h) - need_rows(r - 1, k, h)) * w;
      if (f < 1) f = 1;
      lat += f;
    end
    return lat + h * w * (k * k * t + 2) + 1;
  endfunction

  task automatic build_taps(input int k, input int w, input int h, input int t);
    exp_q.delete();
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        for (int tl = 0; tl < t; tl++)
          for (int ky = 0; ky < k; ky++)
            for (int kx = 0; kx < k; kx++)
              exp_q.push_back({16'(r), 16'(c), 5'(tl), 3'(ky), 3'(kx),
                               1'(tl == t - 1 && ky == k - 1 && kx == k - 1)});
  endtask

  // mode: 0 in_valid high, 1 toggling 1,0,1.., 2 random
  // exp_lat: <0 use model, 0 skip latency check, >0 explicit value
  task automatic run_frame(input int k, input int w, input int h, input int t,
                           input int mode, input bit exp_err, input int exp_lat,
                           input bit start_noise);
    int n, acc_cnt, en_cnt, load_cnt, lat, win;
    bit seen_done, prev_load;
    logic [TW-1:0] got, exp;
    if (exp_err) exp_q.delete();
    else build_taps(k, w, h, t);
    lat = (exp_lat < 0) ? model_latency(k, w, h, t) : exp_lat;
    @(negedge clk);
    cfg_kernel_size  = 3'(k);
    cfg_width_strips = 16'(w);
    cfg_height       = 16'(h);
    cfg_ic_tiles     = 5'(t);
    start    = 1'b1;
    in_valid = 1'b0;
    n = 0; acc_cnt = 0; en_cnt = 0; load_cnt = 0;
    seen_done = 1'b0; prev_load = 1'b0;
    while (!seen_done && n < 5000) begin
      @(negedge clk);
      n++;
      start = start_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      // Config inputs are meaningless once the frame has started
      cfg_kernel_size  = 3'($urandom_range(0, 7));
      cfg_width_strips = 16'($urandom_range(0, 5));
      cfg_height       = 16'($urandom_range(0, 5));
      cfg_ic_tiles     = 5'($urandom_range(0, 20));
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (n % 2 == 1);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (lb_shift_en) begin
        chk("shift_needs_valid", in_valid, 1);
        acc_cnt++;
      end
      if (prev_load) chk("en_after_clear", cu_en, 1);
      if (seq_load) begin
        win = load_cnt;
        load_cnt++;
        chk("clear_with_load", cu_clear, 1);
        chk("load_row", seq_row_idx, 64'(win / w));
        chk("load_col", seq_col_idx, 64'(win % w));
        if (win % w == 0)
          chk("fill_strips", acc_cnt, 64'(need_rows(win / w, k, h) * w));
      end
      if (cu_en) begin
        en_cnt++;
        got = {seq_row_idx, seq_col_idx, ic_tile_idx, kernel_y, kernel_x, acc_last};
        if (exp_q.size() == 0) chk("tap_extra", en_cnt, 64'(h * w * k * k * t));
        else begin
          exp = exp_q.pop_front();
          chk("tap", got, exp);
        end
      end
      if (acc_last) chk("last_with_en", cu_en, 1);
      prev_load = seq_load;
      if (done) seen_done = 1'b1;
    end
    chk("done_seen", seen_done, 1);
    if (seen_done) begin
      if (lat > 0) chk("latency", n, lat);
      chk("cfg_err", cfg_err, exp_err);
      chk("busy_at_done", busy, 1);
      chk("strips_total", acc_cnt, exp_err ? 0 : 64'(h * w));
      chk("cu_en_total", en_cnt, exp_err ? 0 : 64'(h * w * k * k * t));
      chk("windows_total", load_cnt, exp_err ? 0 : 64'(h * w));
      chk("taps_left", exp_q.size(), 0);
    end
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("idle_after_done", {busy, done, cfg_err, cu_en}, 0);
  endtask

  // Reset asserted in the 5th MAC cycle of a basic frame
  task automatic run_reset_abort();
    @(negedge clk);
    cfg_kernel_size = 3'd3; cfg_width_strips = 16'd1;
    cfg_height = 16'd2; cfg_ic_tiles = 5'd1;
    start = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b1;
      rst = (n == 8);
      #1;
      if (n == 8) chk("mac_before_rst", {cu_en, kernel_y, kernel_x}, {1'b1, 3'd1, 3'd1});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_outputs", all_outputs(), 0);
    chk("rst_state", dbg_state, 0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      #1;
      chk("no_done_after_rst", {done, busy}, 0);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int k, w, h, t;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    cfg_kernel_size = '0; cfg_width_strips = '0; cfg_height = '0; cfg_ic_tiles = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", all_outputs(), 0);
    chk("reset_state", dbg_state, 0);
    rst = 1'b0;

    run_frame(3, 1, 2, 1, 0, 1'b0, 26, 1'b0);   // basic frame
    run_frame(5, 2, 3, 2, 0, 1'b0, -1, 1'b0);   // tiling, K=5, W=2
    run_frame(1, 3, 1, 1, 0, 1'b0, -1, 1'b0);   // K=1
    run_frame(3, 1, 2, 1, 1, 1'b0, 27, 1'b0);   // backpressure
    run_frame(4, 1, 2, 1, 0, 1'b1, 1, 1'b0);    // even K
    run_frame(3, 0, 2, 1, 0, 1'b1, 1, 1'b0);    // W=0
    run_frame(3, 1, 2, 0, 0, 1'b1, 1, 1'b0);    // T=0
    run_frame(7, 1, 2, 1, 0, 1'b1, 1, 1'b0);    // K>MAX_K
    run_frame(3, 1, 0, 1, 0, 1'b1, 1, 1'b0);    // H=0
    run_frame(3, 1, 2, 17, 0, 1'b1, 1, 1'b0);   // T>MAX_IC_TILES
    run_reset_abort();
    run_frame(3, 1, 2, 1, 0, 1'b0, 26, 1'b1);   // start pulses while busy
    for (int i = 0; i < 6; i++) begin
      k = 2 * $urandom_range(0, 2) + 1;
      w = $urandom_range(1, 3);
      h = $urandom_range(1, 3);
      t = $urandom_range(1, 3);
      run_frame(k, w, h, t, 2, 1'b0, 0, 1'b0);
      run_frame(k, w, h, t, 0, 1'b0, -1, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
